// File: rtl/vid_pkg.sv
// Shared types and helpers for the video timing / test-pattern generator.
package vid_pkg;

  // One complete mode line. Every field uses the end-position convention:
  // each value is the first position past the region it closes.
  typedef struct packed {
    logic [15:0] width;
    logic [15:0] hfront;
    logic [15:0] hsync;
    logic [15:0] raw_width;
    logic [15:0] height;
    logic [15:0] vfront;
    logic [15:0] vsync;
    logic [15:0] raw_height;
  } mode_t;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;

  // Colour bars, left to right.
  localparam logic [23:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // A mode is usable only if every region is non-empty and ordered inside
  // the raw line/frame, which also keeps all counters within 16 bits.
  function automatic logic mode_valid(input mode_t m);
    return (m.width  != 16'd0) && (m.width  <= m.hfront) &&
           (m.hfront <  m.hsync) && (m.hsync  <  m.raw_width) &&
           (m.height != 16'd0) && (m.height <= m.vfront) &&
           (m.vfront <  m.vsync) && (m.vsync  <  m.raw_height);
  endfunction

endpackage

// File: rtl/vid_pattern.sv
// Test-pattern pixel source. Produces a registered RGB888 pixel aligned with
// the timing decode of the same counter position.
module vid_pattern
  import vid_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_active,
  input  logic [15:0] i_hpos,
  input  logic        i_vpos_bit,
  input  pattern_e    i_pattern,
  input  logic [23:0] i_color,
  input  logic [15:0] i_bar_step,
  output logic [23:0] o_pixel
);

  logic        line_start;
  logic [15:0] bar_cnt;
  logic [15:0] cnt_now;
  logic [2:0]  bar_idx;
  logic [2:0]  idx_now;
  logic [23:0] pix_next;

  // Bar state restarts at the first pixel of every line.
  assign line_start = (i_hpos == 16'd0);
  assign cnt_now    = line_start ? 16'd0 : bar_cnt;
  assign idx_now    = line_start ? 3'd0  : bar_idx;

  // Advance the bar index every i_bar_step pixels, saturating on the last bar.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bar_cnt <= 16'd0;
      bar_idx <= 3'd0;
    end else if (cnt_now == i_bar_step - 16'd1) begin
      bar_cnt <= 16'd0;
      bar_idx <= (idx_now == 3'd7) ? 3'd7 : idx_now + 3'd1;
    end else begin
      bar_cnt <= cnt_now + 16'd1;
      bar_idx <= idx_now;
    end
  end

  // Select the pattern colour for the current position; blank outside active video.
  always_comb begin
    // NOTE: default assignment first so no path leaves pix_next unassigned (no latch).
    pix_next = '0;
    case (i_pattern)
      PAT_SOLID:   pix_next = i_color;
      PAT_BARS:    pix_next = BAR_COLORS[idx_now];
      PAT_RAMP:    pix_next = {3{i_hpos[7:0]}};
      PAT_CHECKER: pix_next = (i_hpos[4] ^ i_vpos_bit) ? COLOR_WHITE : COLOR_BLACK;
      default:     pix_next = '0;
    endcase
    if (!i_active) pix_next = '0;
  end

  // Register the pixel so it lines up with the registered sync outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_pixel <= '0;
    else         o_pixel <= pix_next;
  end

endmodule

// File: rtl/vid_sync_gen.sv
// Programmable video timing generator. Mode line and pattern are shadowed
// while idle and at each frame boundary; outputs are registered one cycle
// after the counter position they describe.
module vid_sync_gen
  import vid_pkg::*;
#(
  parameter bit         OPT_INVERT_HSYNC    = 1'b0,
  parameter bit         OPT_INVERT_VSYNC    = 1'b0,
  parameter logic [1:0] OPT_DEFAULT_PATTERN = 2'b01
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [15:0] i_width,
  input  logic [15:0] i_hfront,
  input  logic [15:0] i_hsync,
  input  logic [15:0] i_raw_width,
  input  logic [15:0] i_height,
  input  logic [15:0] i_vfront,
  input  logic [15:0] i_vsync,
  input  logic [15:0] i_raw_height,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_color,
  output logic        o_pix_valid,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [23:0] o_pixel,
  output logic        o_sof,
  output logic        o_err,
  output logic [15:0] o_frame
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state;
  mode_t       mode_in;
  mode_t       mode;
  pattern_e    pattern;
  logic [23:0] color;
  logic [15:0] hpos;
  logic [15:0] vpos;
  logic [15:0] bar_step;
  logic        in_valid;
  logic        running;
  logic        line_end;
  logic        frame_end;
  logic        reshadow;
  logic        pix_act;
  logic        hs_act;
  logic        vs_act;
  logic        sof_act;

  assign mode_in = '{width: i_width, hfront: i_hfront, hsync: i_hsync,
                     raw_width: i_raw_width, height: i_height, vfront: i_vfront,
                     vsync: i_vsync, raw_height: i_raw_height};
  assign in_valid  = mode_valid(mode_in);
  assign running   = (state == S_RUN);
  assign line_end  = (hpos == mode.raw_width - 16'd1);
  assign frame_end = running && line_end && (vpos == mode.raw_height - 16'd1);
  // Inputs are only looked at while idle or on the last clock of a frame.
  assign reshadow  = !running || frame_end;

  // Combinational decode of the current counter position.
  assign pix_act = running && (hpos < mode.width) && (vpos < mode.height);
  assign hs_act  = running && (hpos >= mode.hfront) && (hpos < mode.hsync);
  assign vs_act  = running && (vpos >= mode.vfront) && (vpos < mode.vsync);
  assign sof_act = running && (hpos == 16'd0) && (vpos == 16'd0);
  assign bar_step = (mode.width[15:3] == 13'd0) ? 16'd1 : {3'b000, mode.width[15:3]};

  // Control FSM: shadow inputs at frame boundaries and step the raster counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      mode    <= '0;
      pattern <= pattern_e'(OPT_DEFAULT_PATTERN);
      color   <= '0;
      hpos    <= '0;
      vpos    <= '0;
      o_err   <= 1'b0;
    end else if (reshadow) begin
      // NOTE: non-blocking (<=) for all state so every register samples pre-edge values.
      mode    <= mode_in;
      pattern <= pattern_e'(i_pattern);
      color   <= i_color;
      hpos    <= '0;
      vpos    <= '0;
      o_err   <= i_en && !in_valid;
      state   <= (i_en && in_valid) ? S_RUN : S_IDLE;
    end else if (line_end) begin
      hpos <= '0;
      vpos <= vpos + 16'd1;
    end else begin
      hpos <= hpos + 16'd1;
    end
  end

  // Registered timing outputs, one cycle behind the counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pix_valid <= 1'b0;
      o_hsync     <= OPT_INVERT_HSYNC;
      o_vsync     <= OPT_INVERT_VSYNC;
      o_sof       <= 1'b0;
      o_frame     <= '0;
    end else begin
      o_pix_valid <= pix_act;
      o_hsync     <= hs_act ^ OPT_INVERT_HSYNC;
      o_vsync     <= vs_act ^ OPT_INVERT_VSYNC;
      o_sof       <= sof_act;
      if (sof_act) o_frame <= o_frame + 16'd1;
    end
  end

  vid_pattern u_pattern (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_active   (pix_act),
    .i_hpos     (hpos),
    .i_vpos_bit (vpos[4]),
    .i_pattern  (pattern),
    .i_color    (color),
    .i_bar_step (bar_step),
    .o_pixel    (o_pixel)
  );

endmodule

// File: tb/tb_vid_sync_gen.sv
// Scoreboard bench for vid_sync_gen: stimulus pushes one descriptor per
// expected frame; the monitor aligns on o_sof and compares every cycle of the
// frame against a raster model computed from the mode-line rules.
module tb_vid_sync_gen;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_en;
  logic [15:0] i_width, i_hfront, i_hsync, i_raw_width;
  logic [15:0] i_height, i_vfront, i_vsync, i_raw_height;
  logic [1:0]  i_pattern;
  logic [23:0] i_color;
  logic        o_pix_valid, o_hsync, o_vsync, o_sof, o_err;
  logic [23:0] o_pixel;
  logic [15:0] o_frame;

  vid_sync_gen dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en),
    .i_width(i_width), .i_hfront(i_hfront), .i_hsync(i_hsync), .i_raw_width(i_raw_width),
    .i_height(i_height), .i_vfront(i_vfront), .i_vsync(i_vsync), .i_raw_height(i_raw_height),
    .i_pattern(i_pattern), .i_color(i_color),
    .o_pix_valid(o_pix_valid), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_pixel(o_pixel),
    .o_sof(o_sof), .o_err(o_err), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          w, hf, hs, rw, h, vf, vs, rh, pat;
    logic [23:0] color;
    logic [15:0] num;
    bit          contig;
  } frame_t;

  localparam int LIMIT = 5000;

  frame_t      exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          frames_done = 0;
  int          stray = 0;
  logic [15:0] exp_frame = 16'd0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected {pix_valid, hsync, vsync, sof, frame, pixel} at raster position (h, v).
  function automatic logic [43:0] model(input frame_t f, input int h, input int v);
    logic        act;
    logic [23:0] pix;
    logic [7:0]  ramp;
    int          step, idx;
    act  = (h < f.w) && (v < f.h);
    step = (f.w / 8 > 0) ? f.w / 8 : 1;
    idx  = h / step;
    if (idx > 7) idx = 7;
    ramp = 8'(h % 256);
    case (f.pat)
      0:       pix = f.color;
      1:       pix = bars[idx];
      2:       pix = {ramp, ramp, ramp};
      default: pix = (((h / 16) % 2) != ((v / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
    if (!act) pix = 24'h0;
    return {act, 1'(h >= f.hf && h < f.hs), 1'(v >= f.vf && v < f.vs),
            1'(h == 0 && v == 0), f.num, pix};
  endfunction

  // Monitor: idle checks between frames, full-frame comparison from each o_sof.
  initial begin : monitor
    frame_t      f;
    int          wait_n, bad;
    bit          aborted;
    logic [43:0] a, e, fa, fe;
    wait_n = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        wait_n = 0;
      end else if (!o_sof) begin
        if (o_pix_valid || o_hsync || o_vsync || o_pixel != 24'h0) stray++;
        if (exp_q.size() != 0) begin
          wait_n++;
          if (wait_n > LIMIT) begin
            f = exp_q.pop_front();
            check("sof_timeout", 64'(wait_n), 64'(0));
            wait_n = 0;
          end
        end
      end else if (exp_q.size() == 0) begin
        stray++;
      end else begin
        f = exp_q.pop_front();
        if (f.contig) check("frame_gap", 64'(wait_n), 64'(0));
        wait_n  = 0;
        bad     = 0;
        aborted = 0;
        fa      = '0;
        fe      = '0;
        for (int t = 0; t < f.rw * f.rh; t++) begin
          if (t > 0) begin
            @(negedge i_clk);
            if (i_reset) begin
              aborted = 1;
              break;
            end
          end
          a = {o_pix_valid, o_hsync, o_vsync, o_sof, o_frame, o_pixel};
          e = model(f, t % f.rw, t / f.rw);
          if (bad == 0) begin
            fa = a;
            fe = e;
          end
          if (a !== e) bad++;
        end
        if (!aborted) begin
          check($sformatf("frame%0d_w%0d_pat%0d", f.num, f.w, f.pat), 64'(fa), 64'(fe));
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_mode(input int w, hf, hs, rw, h, vf, vs, rh, pat, input logic [23:0] col);
    i_width = 16'(w);  i_hfront = 16'(hf); i_hsync = 16'(hs); i_raw_width = 16'(rw);
    i_height = 16'(h); i_vfront = 16'(vf); i_vsync = 16'(vs); i_raw_height = 16'(rh);
    i_pattern = 2'(pat);
    i_color = col;
  endtask

  task automatic push_frame(input bit contig);
    frame_t f;
    exp_frame = exp_frame + 16'd1;
    f.w = int'(i_width);   f.hf = int'(i_hfront); f.hs = int'(i_hsync);  f.rw = int'(i_raw_width);
    f.h = int'(i_height);  f.vf = int'(i_vfront); f.vs = int'(i_vsync);  f.rh = int'(i_raw_height);
    f.pat = int'(i_pattern);
    f.color = i_color;
    f.num = exp_frame;
    f.contig = contig;
    exp_q.push_back(f);
  endtask

  task automatic wait_sof();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_sof && n < LIMIT);
    check("sof_seen", 64'(o_sof), 64'(1));
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < 4 * LIMIT) begin
      @(negedge i_clk);
      n++;
    end
    check("frames_done", 64'(frames_done), 64'(target));
  endtask

  // Run n back-to-back frames with the current inputs, then drop i_en in the
  // last frame and scramble inputs that must be ignored until the boundary.
  task automatic run_frames(input int n);
    int target;
    target = frames_done + n;
    for (int k = 0; k < n; k++) push_frame(k > 0);
    i_en = 1'b1;
    for (int k = 0; k < n; k++) wait_sof();
    i_en = 1'b0;
    i_pattern = 2'($urandom);
    i_color   = 24'($urandom);
    i_width   = 16'($urandom_range(1, 30));
    wait_done(target);
  endtask

  initial begin : stimulus
    int target, n, w, hf, hs, rw, h, vf, vs, rh;
    i_reset = 1'b1;
    i_en    = 1'b0;
    drive_mode(8, 10, 12, 14, 4, 5, 6, 7, 2, 24'h123456);
    #1;
    check("reset_outputs",
          64'({o_pix_valid, o_hsync, o_vsync, o_sof, o_err, o_frame, o_pixel}), 64'(0));
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);

    // Small mode, ramp pattern, three contiguous frames.
    drive_mode(8, 10, 12, 14, 4, 5, 6, 7, 2, 24'h0);
    run_frames(3);
    check("frame_counter", 64'(o_frame), 64'(3));

    // Colour bars: two pixels per bar, then a width whose bars saturate.
    drive_mode(16, 18, 20, 22, 2, 3, 4, 5, 1, 24'h0);
    run_frames(1);
    drive_mode(20, 21, 23, 25, 3, 3, 4, 6, 1, 24'h0);
    run_frames(1);

    // Checker with rows/columns past 16, then solid colour.
    drive_mode(40, 42, 44, 46, 20, 21, 22, 23, 3, 24'h0);
    run_frames(1);
    drive_mode(8, 10, 12, 14, 4, 5, 6, 7, 0, 24'hA5C3E1);
    run_frames(2);

    // Invalid mode (hsync == hfront): refused, then corrected.
    drive_mode(8, 10, 10, 14, 4, 5, 6, 7, 2, 24'h0);
    i_en = 1'b1;
    repeat (20) @(negedge i_clk);
    check("err_on_invalid", 64'(o_err), 64'(1));
    check("frame_held_idle", 64'(o_frame), 64'(exp_frame));
    target = frames_done + 1;
    i_hsync = 16'd12;
    push_frame(1'b0);
    @(negedge i_clk);
    check("err_cleared", 64'(o_err), 64'(0));
    wait_sof();
    i_en = 1'b0;
    wait_done(target);

    // Width change mid-frame applies only from the next frame.
    drive_mode(8, 10, 12, 14, 4, 5, 6, 7, 2, 24'h0);
    target = frames_done + 2;
    push_frame(1'b0);
    i_en = 1'b1;
    wait_sof();
    repeat (28) @(negedge i_clk);
    i_width = 16'd6;
    push_frame(1'b1);
    wait_sof();
    i_en = 1'b0;
    wait_done(target);

    // Asynchronous reset mid-line.
    drive_mode(8, 10, 12, 14, 4, 5, 6, 7, 1, 24'h0);
    push_frame(1'b0);
    i_en = 1'b1;
    wait_sof();
    repeat (20) @(negedge i_clk);
    @(posedge i_clk);
    #2;
    exp_q.delete();
    i_reset = 1'b1;
    #1;
    check("async_reset_outputs",
          64'({o_pix_valid, o_hsync, o_vsync, o_sof, o_err, o_frame, o_pixel}), 64'(0));
    repeat (2) @(negedge i_clk);
    exp_frame = 16'd0;
    target = frames_done + 1;
    push_frame(1'b0);
    i_reset = 1'b0;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_sof && n < 50);
    check("sof_latency_after_reset", 64'(n), 64'(2));
    i_en = 1'b0;
    wait_done(target);

    // Randomized valid modes and patterns.
    repeat (6) begin
      w  = $urandom_range(1, 24);
      hf = w + $urandom_range(0, 3);
      hs = hf + $urandom_range(1, 4);
      rw = hs + $urandom_range(1, 4);
      h  = $urandom_range(1, 8);
      vf = h + $urandom_range(0, 2);
      vs = vf + $urandom_range(1, 3);
      rh = vs + $urandom_range(1, 3);
      drive_mode(w, hf, hs, rw, h, vf, vs, rh, $urandom_range(0, 3), 24'($urandom));
      run_frames(2);
    end

    repeat (10) @(negedge i_clk);
    check("no_stray_outputs", 64'(stray), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
